multicycle_controller: RTL and testbench

Control sequencer for the multicycle variant of the MIPS core. It decodes the opcode and funct fields and steps the shared datapath (one ALU, one unified memory port, register file, PC) through fetch, decode, execute, memory and write-back states. It owns the memory request/ready handshake. It drives every mux select and write enable of the datapath.

---
 rtl/multicycle_controller_if.sv | 49 ++++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the instruction-register fields, ALU flag and memory handshake with
// every datapath control the multicycle sequencer drives.
//   master : controller side (reads op/funct/zero/memready, drives controls)
//   slave  : datapath/memory side (the mirror image)
// Signals:
//   op[5:0], funct[5:0] instruction fields     zero      ALU zero flag
//   memready            access completes now   memreq    access requested
//   iord                address: 0 PC 1 ALUOut memwrite  memory write strobe
//   irwrite             IR load                regwrite  register file write
//   regdst              1 rd, 0 rt             memtoreg  1 MDR, 0 ALUOut
//   alusrca             0 PC, 1 reg A          alusrcb   00 B,01 4,10 imm,11 imm<<2
//   alucontrol[2:0]     ALU operation          pcsrc     00 ALU,01 ALUOut,10 jump
//   pcen                PC load                illegal   unsupported-instr pulse
//   state[3:0]          debug view of the sequencer state
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       memreq;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, memready,
      output memreq, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal, state
   );

   modport slave (
      output op, funct, zero, memready,
      input  memreq, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
             alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control sequencer for the multicycle MIPS core: steps the shared datapath
// through fetch/decode/execute/memory/write-back and owns the memory
// request/ready handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high; returns the sequencer to FETCH
//   bus    multicycle_controller_if.master (instruction fields, flags,
//          memory handshake and all datapath controls)
// -----------------------------------------------------------------------------
module multicycle_controller (
   input  logic                      clk,
   input  logic                      reset,
   multicycle_controller_if.master   bus
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     r_state;
   state_t     w_next;
   logic       w_rtype_ok;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_memreq;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_illegal;

   assign w_rtype_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010};

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Outputs depend on memready in the same cycle so that a zero-wait memory
   // completes a fetch or access without an extra state.
   always_comb begin
      w_next         = S_FETCH;
      w_pcwrite      = 1'b0;
      w_branch       = 1'b0;
      w_memreq       = 1'b0;
      w_memwrite     = 1'b0;
      w_irwrite      = 1'b0;
      w_regwrite     = 1'b0;
      w_illegal      = 1'b0;
      bus.iord       = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.alucontrol = 3'b000;
      bus.pcsrc      = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_memreq       = 1'b1;
            bus.alusrcb    = 2'b01;
            bus.alucontrol = 3'b101;
            if (bus.memready) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end else begin
               w_next    = S_FETCH;
            end
         end
         S_DECODE: begin
            bus.alusrcb    = 2'b11;
            bus.alucontrol = 3'b101;
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               OP_RTYPE: begin
                  if (w_rtype_ok) w_next = S_RTYPEEX;
                  else            w_illegal = 1'b1;
               end
               default:      w_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = 3'b101;
            w_next         = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_memreq = 1'b1;
            bus.iord = 1'b1;
            w_next   = bus.memready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWR: begin
            w_memreq   = 1'b1;
            w_memwrite = 1'b1;
            bus.iord   = 1'b1;
            w_next     = bus.memready ? S_FETCH : S_MEMWR;
         end
         S_MEMWB: begin
            w_regwrite   = 1'b1;
            bus.memtoreg = 1'b1;
         end
         S_RTYPEEX: begin
            bus.alusrca = 1'b1;
            case (bus.funct)
               6'b100000: bus.alucontrol = 3'b101;
               6'b100010: bus.alucontrol = 3'b001;
               6'b100100: bus.alucontrol = 3'b111;
               6'b100101: bus.alucontrol = 3'b110;
               default:   bus.alucontrol = 3'b000;
            endcase
            w_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            bus.regdst = 1'b1;
         end
         S_ADDIEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = 3'b101;
            w_next         = S_IMMWB;
         end
         S_IMMWB: begin
            w_regwrite = 1'b1;
         end
         S_BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = 3'b001;
            bus.pcsrc      = 2'b01;
            w_branch       = 1'b1;
         end
         S_JUMP: begin
            bus.pcsrc = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset masks every side-effecting output so an in-flight access aborts
   // without a write in the reset cycle itself.
   assign bus.memreq   = w_memreq   & ~reset;
   assign bus.memwrite = w_memwrite & ~reset;
   assign bus.irwrite  = w_irwrite  & ~reset;
   assign bus.regwrite = w_regwrite & ~reset;
   assign bus.illegal  = w_illegal  & ~reset;
   assign bus.pcen     = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
   assign bus.state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench: each instruction is expanded into the expected per-cycle
// state list (from opcode class and memory wait counts) plus expected totals
// of write/request activity, and the controller is checked against both.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int st;
      int rdy;   // 0/1 drive that value, 2 = random (ignored by the DUT)
   } ent_t;

   localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00,
                          BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int alu_of(input logic [5:0] f);
      case (f)
         6'h20:   return 5;
         6'h22:   return 1;
         6'h24:   return 7;
         6'h25:   return 6;
         6'h2a:   return 0;
         default: return -1;
      endcase
   endfunction

   // Called #1 after a rising edge when the DUT is expected to be in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                            input logic z, input int fw, input int mw);
      ent_t q[$];
      bit   is_lw, is_sw, is_rt, is_beq, is_addi, is_j, is_ill;
      int   n_ir, n_rw, n_mw, n_pc, n_req, n_ill, we;
      is_lw   = (op == LW);
      is_sw   = (op == SW);
      is_rt   = (op == RT) && (alu_of(f) >= 0);
      is_beq  = (op == BEQ);
      is_addi = (op == ADDI);
      is_j    = (op == JMP);
      is_ill  = !(is_lw || is_sw || is_rt || is_beq || is_addi || is_j);
      for (int i = 0; i < fw; i++) q.push_back('{0, 0});
      q.push_back('{0, 1});
      q.push_back('{1, 2});
      if (is_lw || is_sw) begin
         q.push_back('{2, 2});
         for (int i = 0; i < mw; i++) q.push_back('{is_lw ? 3 : 5, 0});
         q.push_back('{is_lw ? 3 : 5, 1});
         if (is_lw) q.push_back('{4, 2});
      end
      if (is_rt)   begin q.push_back('{6, 2}); q.push_back('{7, 2});  end
      if (is_addi) begin q.push_back('{9, 2}); q.push_back('{10, 2}); end
      if (is_beq)  q.push_back('{8, 2});
      if (is_j)    q.push_back('{11, 2});
      n_ir = 0; n_rw = 0; n_mw = 0; n_pc = 0; n_req = 0; n_ill = 0;
      foreach (q[i]) begin
         bus.op       = op;
         bus.funct    = f;
         bus.zero     = z;
         bus.memready = (q[i].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(q[i].rdy);
         @(negedge clk);
         check("state", bus.state, q[i].st);
         n_ir  += int'(bus.irwrite);
         n_rw  += int'(bus.regwrite);
         n_mw  += int'(bus.memwrite);
         n_pc  += int'(bus.pcen);
         n_req += int'(bus.memreq);
         n_ill += int'(bus.illegal);
         we = int'(bus.irwrite) + int'(bus.regwrite) + int'(bus.memwrite);
         check("single_we", (we <= 1), 1);
         case (q[i].st)
            0: begin
               check("fetch_memreq", bus.memreq, 1);
               check("fetch_iord", bus.iord, 0);
               check("fetch_irwrite", bus.irwrite, q[i].rdy);
            end
            1: if (is_ill) check("decode_illegal", bus.illegal, 1);
            3, 5: begin
               check("mem_iord", bus.iord, 1);
               check("mem_memreq", bus.memreq, 1);
               check("mem_memwrite", bus.memwrite, (q[i].st == 5) ? 1 : 0);
            end
            4: begin
               check("memwb_memtoreg", bus.memtoreg, 1);
               check("memwb_regdst", bus.regdst, 0);
            end
            6: check("rtype_alucontrol", bus.alucontrol, alu_of(f));
            7: begin
               check("aluwb_regdst", bus.regdst, 1);
               check("aluwb_memtoreg", bus.memtoreg, 0);
            end
            8: begin
               check("beq_pcsrc", bus.pcsrc, 1);
               check("beq_pcen", bus.pcen, z);
               check("beq_alucontrol", bus.alucontrol, 1);
            end
            10: begin
               check("immwb_regdst", bus.regdst, 0);
               check("immwb_memtoreg", bus.memtoreg, 0);
            end
            11: check("jump_pcsrc", bus.pcsrc, 2);
            default: ;
         endcase
         @(posedge clk);
         #1;
      end
      check("tot_irwrite", n_ir, 1);
      check("tot_regwrite", n_rw, (is_lw || is_rt || is_addi) ? 1 : 0);
      check("tot_memwrite", n_mw, is_sw ? mw + 1 : 0);
      check("tot_pcen", n_pc, 1 + (is_j ? 1 : 0) + ((is_beq && z) ? 1 : 0));
      check("tot_memreq", n_req, fw + 1 + ((is_lw || is_sw) ? mw + 1 : 0));
      check("tot_illegal", n_ill, is_ill ? 1 : 0);
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] f;
      int         k;

      // Reset: outputs forced quiet even with memready high in FETCH.
      reset        = 1'b1;
      bus.op       = LW;
      bus.funct    = 6'h00;
      bus.zero     = 1'b0;
      bus.memready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_state", bus.state, 0);
      check("rst_memreq", bus.memreq, 0);
      check("rst_irwrite", bus.irwrite, 0);
      check("rst_pcen", bus.pcen, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed cases
      run_instr(LW,   6'h00, 1'b0, 0, 0);
      run_instr(LW,   6'h00, 1'b0, 3, 0);
      run_instr(BEQ,  6'h00, 1'b1, 0, 0);
      run_instr(BEQ,  6'h00, 1'b0, 0, 0);
      run_instr(RT,   6'h2a, 1'b0, 0, 0);
      run_instr(RT,   6'h22, 1'b0, 0, 0);
      run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
      run_instr(RT,   6'h3f, 1'b0, 0, 0);
      run_instr(SW,   6'h00, 1'b0, 0, 2);
      run_instr(ADDI, 6'h00, 1'b1, 1, 0);
      run_instr(JMP,  6'h00, 1'b0, 0, 0);

      // Randomized instruction mix with random wait states
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 7);
         f = 6'($urandom);
         case (k)
            0: op = LW;
            1: op = SW;
            2: begin
               op = RT;
               if ($urandom_range(0, 4) != 0) begin
                  case ($urandom_range(0, 4))
                     0: f = 6'h20;
                     1: f = 6'h22;
                     2: f = 6'h24;
                     3: f = 6'h25;
                     default: f = 6'h2a;
                  endcase
               end
            end
            3: op = BEQ;
            4: op = ADDI;
            5: op = JMP;
            default: op = 6'($urandom);
         endcase
         run_instr(op, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // sw stalled in MEMWR, then reset aborts the access
      bus.op = SW;  bus.funct = 6'h00;  bus.zero = 1'b1;
      bus.memready = 1'b1;
      @(posedge clk); #1;
      bus.memready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.memready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.memready = 1'b0;
      @(negedge clk);
      check("sw_wait_state", bus.state, 5);
      check("sw_wait_memwrite", bus.memwrite, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("sw_rst_memwrite", bus.memwrite, 0);
      check("sw_rst_memreq", bus.memreq, 0);
      check("sw_rst_pcen", bus.pcen, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("sw_after_state", bus.state, 0);
      check("sw_after_pcen", bus.pcen, 0);
      check("sw_after_memwrite", bus.memwrite, 0);
      @(posedge clk); #1;

      // Recovery: a full instruction runs normally after the abort.
      run_instr(LW, 6'h00, 1'b0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
